fft_frame_serializer: RTL and testbench

- Output-side companion to fft_ifft_top: the unloader for the parallel FFT/IFFT result frame.
- Captures one N-sample parallel frame (data_out_re/data_out_im with data_out_valid from fft_ifft_top) in a single cycle.
- Streams the frame one complex sample per cycle, index 0 first, over a valid/ready interface toward the demapper or file-dump logic.
- Mirrors the serial-to-parallel frame loading done on the FFT input side.

---
 rtl/fft_frame_serializer.sv | 178 +++++++++++++++++
 tb/tb_fft_frame_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
// Unloads one parallel N-sample complex frame from the FFT/IFFT core and
// streams it one sample per cycle, index 0 first, over valid/ready.
// Build option: define FFT_SER_DBUF_EN to add a ping-pong pending buffer so
// a second frame can be captured while the first is still streaming.
module fft_frame_serializer #(
  parameter int N     = 64,
  parameter int RE_W  = 16,
  parameter int IM_W  = 16,
  parameter int IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RE_W*N-1:0]   frame_re,
  input  logic [IM_W*N-1:0]   frame_im,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic [RE_W-1:0]     out_re,
  output logic [IM_W-1:0]     out_im,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [RE_W-1:0]    r_out_re;
  logic [IM_W-1:0]    r_out_im;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_overflow;
  logic               r_frame_ready;

  logic [RE_W-1:0]    r_act_re [N];
  logic [IM_W-1:0]    r_act_im [N];

  logic               w_xfer;
  logic               w_last_xfer;
  logic               w_act_from_frame;
  logic               w_act_from_pend;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [RE_W-1:0]    w_first_re;
  logic [IM_W-1:0]    w_first_im;

  assign w_xfer      = r_out_valid && out_ready;
  assign w_last_xfer = w_xfer && (r_idx == LAST_IDX);
  assign w_idx_nxt   = r_idx + 1'b1;

`ifdef FFT_SER_DBUF_EN
  logic [RE_W-1:0]    r_pend_re [N];
  logic [IM_W-1:0]    r_pend_im [N];
  logic               r_pend_full;
  logic               w_pend_load;

  // A frame offered mid-stream parks in the pending buffer; one offered on the
  // last-sample handshake bypasses it and becomes the active frame directly.
  assign w_pend_load      = frame_valid && r_frame_ready && (r_state == S_STREAM) && !w_last_xfer;
  assign w_act_from_pend  = w_last_xfer && r_pend_full;
  assign w_act_from_frame = frame_valid && r_frame_ready && ((r_state == S_IDLE) || w_last_xfer);
  assign w_first_re       = w_act_from_pend ? r_pend_re[0] : frame_re[RE_W-1:0];
  assign w_first_im       = w_act_from_pend ? r_pend_im[0] : frame_im[IM_W-1:0];

  // Pending-buffer occupancy; frame_ready tracks its emptiness one cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full   <= 1'b0;
      r_frame_ready <= 1'b1;
    end else if (w_pend_load) begin
      r_pend_full   <= 1'b1;
      r_frame_ready <= 1'b0;
    end else if (w_act_from_pend) begin
      r_pend_full   <= 1'b0;
      r_frame_ready <= 1'b1;
    end
  end

  // Pending sample storage, written only while a frame is streaming.
  always_ff @(posedge clk) begin
    if (w_pend_load) begin
      for (int k = 0; k < N; k++) begin
        r_pend_re[k] <= frame_re[k*RE_W +: RE_W];
        r_pend_im[k] <= frame_im[k*IM_W +: IM_W];
      end
    end
  end
`else
  assign w_act_from_pend  = 1'b0;
  assign w_act_from_frame = frame_valid && r_frame_ready && (r_state == S_IDLE);
  assign w_first_re       = frame_re[RE_W-1:0];
  assign w_first_im       = frame_im[IM_W-1:0];

  // Single buffer: ready only in IDLE, so a frame on the last handshake drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_ready <= 1'b1;
    end else if (w_act_from_frame) begin
      r_frame_ready <= 1'b0;
    end else if (w_last_xfer) begin
      r_frame_ready <= 1'b1;
    end
  end
`endif

  // Active sample storage, loaded from the input frame or the pending buffer.
  // NOTE: sample storage carries no reset; validity lives in r_state/r_out_valid,
  // so resetting N wide words would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_act_from_frame) begin
      for (int k = 0; k < N; k++) begin
        r_act_re[k] <= frame_re[k*RE_W +: RE_W];
        r_act_im[k] <= frame_im[k*IM_W +: IM_W];
      end
`ifdef FFT_SER_DBUF_EN
    end else if (w_act_from_pend) begin
      r_act_re <= r_pend_re;
      r_act_im <= r_pend_im;
`endif
    end
  end

  // Stream FSM with registered sample outputs and sticky overflow.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (frame_valid && !r_frame_ready) begin
        r_overflow <= 1'b1;
      end

      if (w_act_from_frame || w_act_from_pend) begin
        // New frame: index 0 is presented next cycle (N >= 4, so never last).
        r_state     <= S_STREAM;
        r_idx       <= '0;
        r_out_re    <= w_first_re;
        r_out_im    <= w_first_im;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
      end else if (w_xfer) begin
        if (r_idx == LAST_IDX) begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_out_re    <= '0;
          r_out_im    <= '0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_idx       <= w_idx_nxt;
          r_out_re    <= r_act_re[w_idx_nxt];
          r_out_im    <= r_act_im[w_idx_nxt];
          r_out_last  <= (w_idx_nxt == LAST_IDX);
        end
      end
    end
  end

  assign frame_ready = r_frame_ready;
  assign out_re      = r_out_re;
  assign out_im      = r_out_im;
  assign out_index   = r_idx;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb_fft_frame_serializer
// Directed bench for fft_frame_serializer: single frames with steady and
// throttled ready, dropped/overlapping frames (per build option), and a
// mid-frame reset. Expected samples come from hand-built ramps.
module tb_fft_frame_serializer;

  localparam int N     = 64;
  localparam int RE_W  = 16;
  localparam int IM_W  = 16;
  localparam int IDX_W = 6;

`ifdef FFT_SER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [RE_W*N-1:0]   frame_re;
  logic [IM_W*N-1:0]   frame_im;
  logic                frame_valid;
  logic                frame_ready;
  logic [RE_W-1:0]     out_re;
  logic [IM_W-1:0]     out_im;
  logic [IDX_W-1:0]    out_index;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_re [$];
  logic [15:0] exp_im [$];
  logic [RE_W*N-1:0] inj1_re, inj1_im, inj2_re, inj2_im;

  always #5 clk = ~clk;

  fft_frame_serializer #(.N(N), .RE_W(RE_W), .IM_W(IM_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_re    (frame_re),
    .frame_im    (frame_im),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .out_re      (out_re),
    .out_im      (out_im),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RE_W*N-1:0] mk(input logic [15:0] base);
    logic [RE_W*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*RE_W +: RE_W] = base + 16'(k);
    return v;
  endfunction

  task automatic push_exp(input logic [15:0] rb, input logic [15:0] ib, input int n);
    for (int k = 0; k < n; k++) begin
      exp_re.push_back(rb + 16'(k));
      exp_im.push_back(ib + 16'(k));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] rb, input logic [15:0] ib);
    frame_re    = mk(rb);
    frame_im    = mk(ib);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Drains the expected queue. pat 0: ready held high; pat 1: ready 1,0,0,1.
  // inj1/inj2: pulse frame_valid (with inj*_re/im) while sample #inj is shown.
  task automatic rx(input string tag, input int pat, input int inj1, input int inj2);
    int   cyc = 0;
    int   pos = 0;
    bit   started = 1'b0;
    bit   f1 = 1'b0;
    bit   f2 = 1'b0;
    logic [IDX_W+RE_W+IM_W:0] e;
    while (exp_re.size() != 0 && cyc < 2000) begin
      out_ready   = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      frame_valid = 1'b0;
      if (out_valid && pos == inj1 && !f1) begin
        frame_re = inj1_re; frame_im = inj1_im; frame_valid = 1'b1; f1 = 1'b1;
      end else if (out_valid && pos == inj2 && !f2) begin
        frame_re = inj2_re; frame_im = inj2_im; frame_valid = 1'b1; f2 = 1'b1;
      end
      if (out_valid) begin
        started = 1'b1;
        e = {IDX_W'(pos % N), exp_re[0], exp_im[0], 1'(pos % N == N - 1)};
        check(tag, {out_index, out_re, out_im, out_last}, e);
        if (out_ready) begin
          void'(exp_re.pop_front());
          void'(exp_im.pop_front());
          pos++;
        end
      end else if (started) begin
        check({tag, " gap"}, out_valid, 1'b1);
        break;
      end
      tick();
      cyc++;
    end
    frame_valid = 1'b0;
    if (exp_re.size() != 0) begin
      check({tag, " timeout"}, exp_re.size(), 0);
      exp_re.delete();
      exp_im.delete();
    end
  endtask

  initial begin
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    frame_re    = '0;
    frame_im    = '0;
    inj1_re = '0; inj1_im = '0; inj2_re = '0; inj2_im = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #2;
    check("rst out_valid", out_valid, 0);
    check("rst frame_ready", frame_ready, 1);
    check("rst overflow", overflow, 0);
    check("rst outputs", {out_index, out_re, out_im, out_last}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single frame, ready held high
    check("idle frame_ready", frame_ready, 1);
    push_exp(16'h0100, 16'hF000, N);
    send(16'h0100, 16'hF000);
    check("t1 latency", out_valid, 1);
    check("t1 busy frame_ready", frame_ready, DBUF);
    rx("t1 sample", 0, -1, -1);
    check("t1 valid after last", out_valid, 0);
    check("t1 frame_ready after", frame_ready, 1);
    check("t1 overflow", overflow, 0);

    // Same frame, ready toggling 1,0,0,1
    push_exp(16'h0100, 16'hF000, N);
    send(16'h0100, 16'hF000);
    rx("t2 sample", 1, -1, -1);
    check("t2 valid after last", out_valid, 0);

`ifndef FFT_SER_DBUF_EN
    // Frame on the last-sample handshake is dropped and flags overflow
    inj2_re = mk(16'h5000); inj2_im = mk(16'h5800);
    push_exp(16'h0200, 16'h0300, N);
    send(16'h0200, 16'h0300);
    rx("t3a sample", 0, -1, N - 1);
    check("t3a last-cycle frame dropped", out_valid, 0);
    check("t3a overflow", overflow, 1);
    tick();
    check("t3a still idle", out_valid, 0);

    // Frame at index 20 is dropped; running frame is unaffected
    inj1_re = mk(16'h6000); inj1_im = mk(16'h6800);
    push_exp(16'h0400, 16'h0500, N);
    send(16'h0400, 16'h0500);
    rx("t3b sample", 0, 20, -1);
    check("t3b mid frame dropped", out_valid, 0);
    repeat (5) tick();
    check("t3b overflow sticky", overflow, 1);
    check("t3b still idle", out_valid, 0);
`else
    // Back-to-back A then B (B at index 10): 128 samples, no gap
    inj1_re = mk(16'd100); inj1_im = mk(16'h8100);
    push_exp(16'd0, 16'h8000, N);
    push_exp(16'd100, 16'h8100, N);
    send(16'd0, 16'h8000);
    rx("t4 sample", 0, 10, -1);
    check("t4 valid after B", out_valid, 0);
    check("t4 overflow", overflow, 0);

    // Frame on last handshake with pending empty streams next, no overflow
    inj2_re = mk(16'h0700); inj2_im = mk(16'h0780);
    push_exp(16'h0010, 16'h0020, N);
    push_exp(16'h0700, 16'h0780, N);
    send(16'h0010, 16'h0020);
    rx("t4b sample", 0, -1, N - 1);
    check("t4b valid after D", out_valid, 0);
    check("t4b overflow", overflow, 0);

    // Third frame C while B pending: dropped, overflow set
    inj1_re = mk(16'd100);    inj1_im = mk(16'h8100);
    inj2_re = mk(16'h3000);   inj2_im = mk(16'h3800);
    push_exp(16'd0, 16'h8000, N);
    push_exp(16'd100, 16'h8100, N);
    send(16'd0, 16'h8000);
    rx("t5 sample", 0, 10, 20);
    check("t5 C never output", out_valid, 0);
    check("t5 overflow", overflow, 1);
    repeat (3) tick();
    check("t5 still idle", out_valid, 0);
`endif

    // Reset at sample index 30, released 3 cycles later
    push_exp(16'h0900, 16'h0A00, 30);
    send(16'h0900, 16'h0A00);
    rx("t6 pre-reset", 0, -1, -1);
    check("t6 pre-reset index", {out_valid, out_index}, {1'b1, IDX_W'(30)});
    rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", out_valid, 0);
    check("t6 rst frame_ready", frame_ready, 1);
    check("t6 rst overflow", overflow, 0);
    check("t6 rst outputs", {out_index, out_re, out_im, out_last}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6 no partial output", out_valid, 0);
    push_exp(16'h0B00, 16'h0C00, N);
    send(16'h0B00, 16'h0C00);
    check("t6 new frame latency", out_valid, 1);
    rx("t6 post-reset", 0, -1, -1);
    check("t6 valid after last", out_valid, 0);
    check("t6 overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
